// File: rtl/counter_delta_pkg.sv
// Shared types for the running-total to increment decoder: default widths, FSM states, FIFO entry.
// The amt field width is fixed by DEF_AMT_W; a wider AMT_W needs this constant raised.
package counter_delta_pkg;

  localparam int DEF_TOT_W = 8;
  localparam int DEF_AMT_W = 4;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_t;

  typedef struct packed {
    logic                 inc;
    logic [DEF_AMT_W-1:0] amt;
  } delta_entry_t;

endpackage

// File: rtl/counter_delta_fifo.sv
// Synchronous FIFO of decoded (inc, amt) entries with a registered head entry.
// Latency: a push into an empty FIFO is visible at head after the same edge.
// Backpressure: pushes while full and pops while empty are ignored; no full-FIFO pass-through.
module counter_delta_fifo
  import counter_delta_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  delta_entry_t push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output delta_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  delta_entry_t  mem [DEPTH];
  delta_entry_t  head_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;
  assign head    = head_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      // Head tracks the oldest entry; with one entry left a pop hands over to the incoming push.
      if (do_pop) begin
        if (count > (PW+1)'(1)) begin
          head_q <= mem[rd_nxt];
        end else if (do_push) begin
          head_q <= push_dat;
        end
      end else if (do_push && empty) begin
        head_q <= push_dat;
      end
    end
  end

endmodule

// File: rtl/counter_delta_decoder.sv
// Recovers (inc, amt) pairs from a running-total stream; optional stats via COUNTER_DELTA_DECODER_STATS_EN.
// Latency: a pair decoded from a sample accepted at edge N is at the output in cycle N+1 when the buffer was empty.
// Backpressure: io_in_ready = !fifo_full; a full buffer holds the input until a pop has completed.
module counter_delta_decoder
  import counter_delta_pkg::*;
#(
  parameter int TOT_W      = DEF_TOT_W,
  parameter int AMT_W      = DEF_AMT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [TOT_W-1:0] io_in_tot,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_out_inc,
  output logic [AMT_W-1:0] io_out_amt,
  output logic             io_err
`ifdef COUNTER_DELTA_DECODER_STATS_EN
  ,
  output logic [15:0]      io_samples,
  output logic [7:0]       io_range_errs
`endif
);

  state_t                   state_q;
  state_t                   state_d;
  logic [TOT_W-1:0]         prev_q;
  logic [TOT_W-1:0]         delta;
  logic [TOT_W+AMT_W-1:0]   delta_ext;
  logic                     in_range;
  logic                     accept;
  logic                     push;
  logic                     range_err;
  logic                     err_q;
  logic                     fifo_full;
  logic                     fifo_empty;
  delta_entry_t             push_dat;
  delta_entry_t             head;

  assign accept      = io_in_valid && io_in_ready;
  assign io_in_ready = !fifo_full;
  assign delta       = io_in_tot - prev_q;
  // Zero-extending before the range test keeps it legal even when AMT_W >= TOT_W.
  assign delta_ext   = {{AMT_W{1'b0}}, delta};
  assign in_range    = (delta_ext[TOT_W+AMT_W-1:AMT_W] == '0);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_dat  = '0;
    range_err = 1'b0;
    if (accept) begin
      case (state_q)
        EMPTY: begin
          state_d = PRIMED;
        end
        PRIMED: begin
          if (in_range) begin
            push         = 1'b1;
            push_dat.inc = (delta != '0);
            push_dat.amt = DEF_AMT_W'(delta_ext[AMT_W-1:0]);
          end else begin
            range_err = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        prev_q <= io_in_tot;
      end
      if (range_err) begin
        err_q <= 1'b1;
      end
    end
  end

  counter_delta_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (io_out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign io_out_valid = !fifo_empty;
  assign io_out_inc   = head.inc;
  assign io_out_amt   = AMT_W'(head.amt);
  assign io_err       = err_q;

`ifdef COUNTER_DELTA_DECODER_STATS_EN
  logic [15:0] samples_q;
  logic [7:0]  range_errs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      samples_q    <= '0;
      range_errs_q <= '0;
    end else begin
      if (accept && (samples_q != '1)) begin
        samples_q <= samples_q + 1'b1;
      end
      if (range_err && (range_errs_q != '1)) begin
        range_errs_q <= range_errs_q + 1'b1;
      end
    end
  end

  assign io_samples    = samples_q;
  assign io_range_errs = range_errs_q;
`endif

endmodule

// File: tb/tb_counter_delta_decoder.sv
// Directed bench for counter_delta_decoder with a queue-based reference model checked every cycle.
module tb_counter_delta_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_tot;
  logic       out_valid;
  logic       out_ready;
  logic       out_inc;
  logic [3:0] out_amt;
  logic       err;
`ifdef COUNTER_DELTA_DECODER_STATS_EN
  logic [15:0] samples;
  logic [7:0]  range_errs;
`endif

  always #5 clk = ~clk;

  counter_delta_decoder #(
    .TOT_W      (8),
    .AMT_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_tot    (in_tot),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_inc   (out_inc),
    .io_out_amt   (out_amt),
    .io_err       (err)
`ifdef COUNTER_DELTA_DECODER_STATS_EN
    ,
    .io_samples    (samples),
    .io_range_errs (range_errs)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending pairs as {inc, amt}, plus previous total and sticky error.
  logic [4:0] exp_q[$];
  logic [4:0] got[$];
  bit         m_primed = 0;
  int         m_prev   = 0;
  bit         m_err    = 0;
  int         m_samples = 0;
  int         m_rerrs   = 0;
  bit         m_full;
  int         m_delta;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(exp_q.size() < 4));
    chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head", int'({out_inc, out_amt}), int'(exp_q[0]));
    chk("err", int'(err), int'(m_err));
`ifdef COUNTER_DELTA_DECODER_STATS_EN
    chk("samples", int'(samples), m_samples);
    chk("range_errs", int'(range_errs), m_rerrs);
`endif
    if (reset) begin
      exp_q.delete();
      m_primed  = 0;
      m_prev    = 0;
      m_err     = 0;
      m_samples = 0;
      m_rerrs   = 0;
    end else begin
      m_full = (exp_q.size() == 4);
      if (exp_q.size() != 0 && out_ready) begin
        got.push_back({out_inc, out_amt});
        void'(exp_q.pop_front());
      end
      if (in_valid && !m_full) begin
        if (m_samples < 65535) m_samples++;
        if (m_primed) begin
          m_delta = (int'(in_tot) - m_prev) & 255;
          if (m_delta == 0) exp_q.push_back(5'd0);
          else if (m_delta < 16) exp_q.push_back({1'b1, m_delta[3:0]});
          else begin
            m_err = 1;
            if (m_rerrs < 255) m_rerrs++;
          end
        end
        m_primed = 1;
        m_prev   = int'(in_tot);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(input string name);
    bit hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    chk(name, int'(hs), 1);
    in_valid = 1'b0;
  endtask

  task automatic send(input int t);
    in_valid = 1'b1;
    in_tot   = t[7:0];
    wait_accept("accept_timeout");
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    step(1);
    reset    = 1'b0;
    got.delete();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_tot    = 8'd0;
    out_ready = 1'b1;
    step(2);
    reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pair", int'({out_inc, out_amt}), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #1;

    // Priming and normal decode
    do_reset();
    send(0); send(3); send(3); send(18);
    step(3);
    chk("t1_count", got.size(), 3);
    chk("t1_p0", int'(got[0]), 19);
    chk("t1_p1", int'(got[1]), 0);
    chk("t1_p2", int'(got[2]), 31);
    chk("t1_err", int'(err), 0);

    // Wrap-around
    do_reset();
    send(250); send(4);
    step(3);
    chk("t2_count", got.size(), 1);
    chk("t2_p0", int'(got[0]), 26);
    chk("t2_err", int'(err), 0);

    // Range error then recovery
    do_reset();
    send(10); send(30);
    @(negedge clk);
    chk("t3_err_next", int'(err), 1);
    @(posedge clk);
    #1;
    send(31);
    step(3);
    chk("t3_count", got.size(), 1);
    chk("t3_p0", int'(got[0]), 17);
    chk("t3_err_sticky", int'(err), 1);
`ifdef COUNTER_DELTA_DECODER_STATS_EN
    chk("t3_samples", int'(samples), 3);
    chk("t3_range_errs", int'(range_errs), 1);
`endif

    // Backpressure: fill the buffer, hold the sixth sample
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i);
    @(negedge clk);
    chk("t4_full_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_tot   = 8'd5;
    step(3);
    out_ready = 1'b1;
    wait_accept("t4_held_accept");
    step(8);
    chk("t4_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t4_pair", int'(got[i]), 17);

    // Reset with three entries buffered
    do_reset();
    out_ready = 1'b0;
    send(0); send(1); send(2); send(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_flushed", int'(out_valid), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got.delete();
    send(7); send(9);
    step(3);
    chk("t5_count", got.size(), 1);
    chk("t5_p0", int'(got[0]), 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_delta_decoder.md
# counter_delta_decoder

Inverse of the `Counter` datapath: it consumes a stream of running totals, as the `Counter` produces on `io_tot`, and recovers the `(io_inc, io_amt)` increment stream that generated them. It sits on the observation side of the `Counter` test path. A tap on the total feeds it, and its output is compared against the stimulus that was applied to the `Counter`. Decoded pairs are buffered in a small FIFO with valid/ready handshakes on both sides. Deltas that a single increment cannot represent are flagged.

## Interface
Parameters:
- `TOT_W`, default 8: width of the running total.
- `AMT_W`, default 4: width of a recovered increment amount.
- `FIFO_DEPTH`, default 4: number of output buffer entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_in_valid`  in  1  total sample present.
- `io_in_ready`  out  1  decoder can accept a sample.
- `io_in_tot`  in  `TOT_W`  running-total sample.
- `io_out_valid`  out  1  decoded pair available.
- `io_out_ready`  in  1  consumer takes the pair.
- `io_out_inc`  out  1  recovered increment enable.
- `io_out_amt`  out  `AMT_W`  recovered amount.
- `io_err`  out  1  sticky range error.

## Operation
- **Accept and pop rules.**
  - A sample is accepted when `io_in_valid && io_in_ready`.
  - `io_in_ready = !fifo_full`. There is no pass-through: when the FIFO is full, a same-cycle pop does not make room for a same-cycle push.
  - A pop occurs when `io_out_valid && io_out_ready`.
- **State machine.** Two states, `EMPTY` and `PRIMED`.
  - `EMPTY`: an accepted sample loads `prev`, pushes nothing, and moves the state to `PRIMED`.
  - `PRIMED`: an accepted sample computes `delta = (io_in_tot - prev) mod 2^TOT_W`. Subtraction is unsigned and `TOT_W` bits wide, so 250 followed by 4 gives `delta` = 10. `prev` is updated on every accepted sample.
- **Decoding in `PRIMED`.**
  - `delta` == 0: push inc=0, amt=0.
  - 1 ≤ `delta` ≤ 2^AMT_W−1: push inc=1, amt=`delta[AMT_W-1:0]`.
  - `delta` ≥ 2^AMT_W: nothing is pushed, `io_err` is set, and `prev` is still updated.
- **Error flag.** `io_err` stays high until reset. Decoding continues after an error.
- **Output.** `io_out_inc` and `io_out_amt` show the FIFO head. They hold stable while `io_out_valid` is high and `io_out_ready` is low.

## Timing
- **Reset values.** `io_in_ready`=1, `io_out_valid`=0, `io_out_inc`=0, `io_out_amt`=0, `io_err`=0. State is `EMPTY`, `prev`=0, and the FIFO is empty.
- **Reset mid-operation.** All buffered pairs are discarded and the next accepted sample re-primes.
- **Latency.** A sample accepted at edge N has its pair visible at `io_out_valid` after edge N, i.e. in cycle N+1, provided the FIFO was empty.
- **Throughput.** One sample per cycle while `io_out_ready` is held high.
- **Simultaneous push and pop.** When the FIFO is non-empty and not full, a push and a pop in the same cycle leave the occupancy unchanged.
- **Full.** With `FIFO_DEPTH` entries held, `io_in_ready` is 0 in the following cycle.
- **Error timing.** `io_err` rises in the cycle after the offending sample is accepted.

## Configuration
- **`COUNTER_DELTA_DECODER_STATS_EN` defined:** adds two outputs.
  - `io_samples`, out, 16 bits: count of accepted samples.
  - `io_range_errs`, out, 8 bits: count of range-error events.
  - Both counters saturate at all-ones and are cleared by `reset`.
- **Macro undefined:** these ports and counters are absent. All other behaviour is identical.

## Structure
- **Package `counter_delta_pkg`:**
  - default `TOT_W` and `AMT_W` constants;
  - state enum `{EMPTY, PRIMED}`;
  - packed struct `delta_entry_t {inc, amt}` for FIFO entries.
- **Sub-module `counter_delta_fifo`:** synchronous FIFO of `delta_entry_t`, parameterised by `FIFO_DEPTH`. Provides push/pop, full/empty, and a registered head. The top level holds the state machine, `prev`, the subtractor/classifier, the error flag and the optional stats counters.

## Test plan
- **Priming and normal decode.** After reset, samples 0, 3, 3, 18 with `io_out_ready`=1 → outputs (1,3), (0,0), (1,15); `io_err`=0.
- **Wrap-around.** Samples 250, 4 → one output (1,10); no error.
- **Range error.** Samples 10, 30 → no output and `io_err`=1 from the next cycle. A following sample of 31 → (1,1), and `io_err` stays 1.
- **Backpressure.** `io_out_ready`=0, six samples 0, 1, 2, 3, 4, 5 → `io_in_ready` drops after the 4-entry FIFO fills, and the 6th sample is held. Raising `io_out_ready` → (1,1) ×5 in order with no loss.
- **Reset mid-stream.** Reset pulsed while 3 entries are buffered → `io_out_valid`=0 the next cycle; samples 7, 9 → single output (1,2).
- **Stats, with `COUNTER_DELTA_DECODER_STATS_EN` defined.** Run the range-error scenario → `io_samples`=3, `io_range_errs`=1.
